// File: rtl/reg_override_ctrl.sv
// Override arbiter for a W-bit state register: functional D/enable capture when idle,
// round-robin granted hold of a requester's value for a programmed number of cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------------
// ST_IDLE    | no override; q captures d_in on d_en; arbitrate pending requests
// ST_HOLD    | q frozen at the winner's latched value; gnt one-hot; cnt counts down
// ST_RELEASE | single cycle; gnt low, done high; pointer advances past the winner
module reg_override_ctrl #(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [W-1:0]         d_in,
    input  logic                 d_en,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*W-1:0]    req_val,
    input  logic [NREQ*CNTW-1:0] req_len,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         q
);

    localparam int              IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDXW:0]   NREQ_W   = (IDXW + 1)'(NREQ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [W-1:0]      q_q, q_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   win_q, win_d;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [IDXW-1:0]   rot_off;
    logic [IDXW:0]     pick_sum;
    logic [IDXW-1:0]   pick_idx;
    logic [W-1:0]      pick_val;
    logic [CNTW-1:0]   pick_len;
    logic [CNTW-1:0]   hold_len;
    logic              win_req;
    logic [IDXW-1:0]   ptr_next;

    // Rotate requests so the pointer lands at bit 0; lowest set bit is the winner offset.
    always_comb begin
        req_dbl = {req, req} >> ptr_q;
        req_rot = req_dbl[NREQ-1:0];
        rot_off = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                rot_off = IDXW'(j);
            end
        end
        pick_sum = {1'b0, ptr_q} + {1'b0, rot_off};
        if (pick_sum >= NREQ_W) begin
            pick_idx = IDXW'(pick_sum - NREQ_W);
        end else begin
            pick_idx = pick_sum[IDXW-1:0];
        end
    end

    always_comb begin
        pick_val = '0;
        pick_len = '0;
        win_req  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDXW'(i)) begin
                pick_val = req_val[i*W +: W];
                pick_len = req_len[i*CNTW +: CNTW];
            end
            if (win_q == IDXW'(i)) begin
                win_req = req[i];
            end
        end
    end

    assign hold_len = (pick_len == '0) ? CNTW'(1) : pick_len;
    assign ptr_next = (win_q == LAST_IDX) ? '0 : win_q + IDXW'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_HOLD;
                    gnt_d   = NREQ'(1) << pick_idx;
                    q_d     = pick_val;
                    cnt_d   = hold_len;
                    win_d   = pick_idx;
                end else if (d_en) begin
                    q_d = d_in;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNTW'(1);
                end
                // Owner dropping its request aborts the hold on the very next edge.
                if (!win_req || cnt_q <= CNTW'(1)) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = ptr_next;
                if (d_en) begin
                    q_d = d_in;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    assign gnt  = gnt_q;
    assign q    = q_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_RELEASE);

endmodule

// File: tb/tb_reg_override_ctrl.sv
// Directed bench for reg_override_ctrl: vector table for the cycle-by-cycle flow,
// hand sequences for early abort, asynchronous reset mid-hold and round-robin rotation.
module tb_reg_override_ctrl;

    logic        clk;
    logic        rstn;
    logic [7:0]  d_in;
    logic        d_en;
    logic [3:0]  req;
    logic [31:0] req_val;
    logic [31:0] req_len;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [7:0]  q;

    int checks;
    int errors;

    reg_override_ctrl #(.W(8), .NREQ(4), .CNTW(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .d_in    (d_in),
        .d_en    (d_en),
        .req     (req),
        .req_val (req_val),
        .req_len (req_len),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        d_en;
        logic [7:0]  d_in;
        logic [3:0]  req;
        logic [31:0] len;
        logic [31:0] val;
        logic [3:0]  e_gnt;
        logic        e_busy;
        logic        e_done;
        logic [7:0]  e_q;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] VD = 32'h44_3C_22_11;
    localparam logic [31:0] VC = 32'h44_3C_99_11;
    localparam logic [31:0] LS = 32'h01_03_01_01;
    localparam logic [31:0] L0 = 32'h00_00_00_00;
    localparam logic [31:0] L2 = 32'h02_02_02_02;

    task automatic add(input logic de, input logic [7:0] di, input logic [3:0] rq,
                       input logic [31:0] ln, input logic [31:0] vl, input logic [3:0] eg,
                       input logic eb, input logic ed, input logic [7:0] eq);
        vec_t v;
        v.d_en = de; v.d_in = di; v.req = rq; v.len = ln; v.val = vl;
        v.e_gnt = eg; v.e_busy = eb; v.e_done = ed; v.e_q = eq;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eg, input logic eb,
                             input logic ed, input logic [7:0] eq);
        check({tag, " gnt"},  8'(gnt),  8'(eg));
        check({tag, " busy"}, 8'(busy), 8'(eb));
        check({tag, " done"}, 8'(done), 8'(ed));
        check({tag, " q"},    q,        eq);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_v [4];
        logic [3:0] oh;
        exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h3C; exp_v[3] = 8'h44;
        checks = 0;
        errors = 0;

        // functional capture and hold
        add(1, 8'hA5, 4'b0000, LS, VD, 4'b0000, 0, 0, 8'hA5);
        add(0, 8'h5A, 4'b0000, LS, VD, 4'b0000, 0, 0, 8'hA5);
        add(1, 8'h5A, 4'b0000, LS, VD, 4'b0000, 0, 0, 8'h5A);
        // single override on requester 2, len 3, d_en toggling underneath
        add(1, 8'h01, 4'b0100, LS, VD, 4'b0100, 1, 0, 8'h3C);
        add(1, 8'h02, 4'b0100, LS, VD, 4'b0100, 1, 0, 8'h3C);
        add(1, 8'h03, 4'b0100, LS, VD, 4'b0100, 1, 0, 8'h3C);
        add(1, 8'h04, 4'b0100, LS, VD, 4'b0000, 1, 1, 8'h3C);
        add(1, 8'h05, 4'b0000, LS, VD, 4'b0000, 0, 0, 8'h05);
        add(1, 8'h06, 4'b0000, LS, VD, 4'b0000, 0, 0, 8'h06);
        // len 0 acts as 1; pointer at 3 wraps to requester 0
        add(0, 8'h00, 4'b0001, L0, VD, 4'b0001, 1, 0, 8'h11);
        add(0, 8'h00, 4'b0001, L0, VD, 4'b0000, 1, 1, 8'h11);
        add(0, 8'h00, 4'b0001, L0, VD, 4'b0000, 0, 0, 8'h11);
        add(0, 8'h00, 4'b0001, L0, VD, 4'b0001, 1, 0, 8'h11);
        add(0, 8'h00, 4'b0000, L0, VD, 4'b0000, 1, 1, 8'h11);
        add(0, 8'h00, 4'b0000, L0, VD, 4'b0000, 0, 0, 8'h11);
        add(1, 8'h77, 4'b0000, L0, VD, 4'b0000, 0, 0, 8'h77);
        // override beats d_en; req_val change during hold is ignored
        add(1, 8'h88, 4'b1010, L2, VD, 4'b0010, 1, 0, 8'h22);
        add(1, 8'h89, 4'b1010, L2, VC, 4'b0010, 1, 0, 8'h22);
        add(1, 8'h8A, 4'b1010, L2, VC, 4'b0000, 1, 1, 8'h22);
        add(0, 8'h8B, 4'b1010, L2, VC, 4'b0000, 0, 0, 8'h22);
        add(0, 8'h00, 4'b1010, L2, VC, 4'b1000, 1, 0, 8'h44);
        add(0, 8'h00, 4'b1010, L2, VC, 4'b1000, 1, 0, 8'h44);
        add(0, 8'h00, 4'b1010, L2, VC, 4'b0000, 1, 1, 8'h44);
        add(1, 8'hC3, 4'b0000, L2, VC, 4'b0000, 0, 0, 8'hC3);

        rstn = 1'b0; d_in = '0; d_en = 1'b0; req = '0; req_val = VD; req_len = LS;
        #12;
        check_all("reset", 4'b0000, 0, 0, 8'h00);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            d_en = tbl[i].d_en; d_in = tbl[i].d_in; req = tbl[i].req;
            req_len = tbl[i].len; req_val = tbl[i].val;
            step();
            check_all($sformatf("row%0d", i), tbl[i].e_gnt, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_q);
        end

        // early abort: len 10, request dropped after 4 grant cycles
        req_val = VD; req_len = 32'h01_0A_01_01; d_en = 0; req = 4'b0100;
        step();
        check_all("abort grant", 4'b0100, 1, 0, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("abort hold%0d", i), 4'b0100, 1, 0, 8'h3C);
        end
        req = 4'b0000;
        step();
        check_all("abort release", 4'b0000, 1, 1, 8'h3C);
        step();
        check_all("abort idle", 4'b0000, 0, 0, 8'h3C);
        step();
        check_all("abort keep", 4'b0000, 0, 0, 8'h3C);
        d_en = 1; d_in = 8'hE1;
        step();
        check_all("abort capture", 4'b0000, 0, 0, 8'hE1);
        d_en = 0;

        // asynchronous reset in the middle of a hold (pointer is 3, so requester 1 wins)
        req = 4'b0010; req_len = 32'h05_05_05_05;
        step();
        check_all("rst grant", 4'b0010, 1, 0, 8'h22);
        step();
        check_all("rst hold", 4'b0010, 1, 0, 8'h22);
        #2 rstn = 1'b0;
        #1;
        check_all("rst async", 4'b0000, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("rst low%0d", i), 4'b0000, 0, 0, 8'h00);
        end
        req = 4'b0000; rstn = 1'b1;
        step();
        check_all("rst after", 4'b0000, 0, 0, 8'h00);

        // round-robin from a freshly reset pointer
        req = 4'b1111; req_len = 32'h01_01_01_01; req_val = VD; d_en = 0;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            step();
            check_all($sformatf("rr%0d grant", k), oh, 1, 0, exp_v[k % 4]);
            step();
            check_all($sformatf("rr%0d release", k), 4'b0000, 1, 1, exp_v[k % 4]);
            step();
            check_all($sformatf("rr%0d idle", k), 4'b0000, 0, 0, exp_v[k % 4]);
        end
        req = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
